// File: rtl/i2c_reg_xfer.sv
// i2c_reg_xfer: turns one register read/write request into the complete
// START / address / sub-address / RESTART / data / STOP command sequence
// for the byte-level I2C master, and reports a single done pulse plus an
// error code.
module i2c_reg_xfer #(
    parameter int LEN_W = 3,
    parameter int C_SZ  = 5,
    parameter int S_SZ  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             rnw,
    input  logic [6:0]       dev,
    input  logic [7:0]       reg_a,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    output logic             wr_take,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err,
    output logic [C_SZ-1:0]  m_cmd,
    output logic [7:0]       m_dat,
    output logic             m_ws,
    input  logic [S_SZ-1:0]  m_stat,
    input  logic [7:0]       m_dat_out
);

    // Master command flags; combined by OR into one command word.
    localparam logic [C_SZ-1:0] C_STRT = C_SZ'(5'b00001);
    localparam logic [C_SZ-1:0] C_STOP = C_SZ'(5'b00010);
    localparam logic [C_SZ-1:0] C_READ = C_SZ'(5'b00100);
    localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(5'b01000);
    localparam logic [C_SZ-1:0] C_NACK = C_SZ'(5'b10000);

    // Master status: three flag bits, then an error code field (0 = no error).
    localparam int SB_BSY = 0;
    localparam int SB_DON = 1;
    localparam int SB_ACK = 2;
    localparam int SF_LO  = 3;
    localparam int SF_W   = S_SZ - SF_LO;
    localparam logic [SF_W-1:0] S_OK  = '0;
    localparam logic [SF_W-1:0] S_ALO = SF_W'(1);
    localparam logic [SF_W-1:0] S_BBL = SF_W'(2);

    // Result codes reported on err.
    localparam logic [2:0] E_OK    = 3'd0;
    localparam logic [2:0] E_DNACK = 3'd1;
    localparam logic [2:0] E_RNACK = 3'd2;
    localparam logic [2:0] E_WNACK = 3'd3;
    localparam logic [2:0] E_ALO   = 3'd4;
    localparam logic [2:0] E_BBL   = 3'd5;
    localparam logic [2:0] E_CMD   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_EVAL, ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        P_ADDR, P_REG, P_RADDR, P_DATA, P_STOP
    } phase_e;

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             rnw_q, rnw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       err_q, err_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [C_SZ-1:0]  m_cmd_q, m_cmd_d;
    logic [7:0]       m_dat_q, m_dat_d;
    logic             m_ws_q, m_ws_d;

    logic [SF_W-1:0]  stat_code;
    logic             rd_byte;
    logic             last_wr;
    logic             fin;

    assign stat_code = m_stat[S_SZ-1:SF_LO];
    // Current phase is a data byte being read (the only non-write command).
    assign rd_byte   = (phase_q == P_DATA) && rnw_q;
    // Current phase is the final write byte, which carried STOP.
    assign last_wr   = (phase_q == P_DATA) && !rnw_q && (cnt_q == '0);

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        // NOTE: every _d starts from its _q (or its pulse default) so no branch leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        phase_d    = phase_q;
        rnw_d      = rnw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        m_cmd_d    = m_cmd_q;
        m_dat_d    = m_dat_q;
        m_ws_d     = m_ws_q;
        fin        = 1'b0;

        case (state_q)
            // FIN accepts a new request exactly like IDLE, so back-to-back
            // requests issued in the done cycle are not lost.
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (req) begin
                    rnw_d   = rnw;
                    dev_d   = dev;
                    reg_d   = reg_a;
                    cnt_d   = len;
                    err_d   = E_OK;
                    phase_d = P_ADDR;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                m_ws_d  = 1'b1;
                state_d = ST_ISSUE;
                case (phase_q)
                    P_ADDR: begin
                        m_cmd_d = C_STRT | C_WRTE;
                        m_dat_d = {dev_q, 1'b0};
                    end
                    P_REG: begin
                        m_cmd_d = C_WRTE;
                        m_dat_d = reg_q;
                    end
                    P_RADDR: begin
                        m_cmd_d = C_STRT | C_WRTE;
                        m_dat_d = {dev_q, 1'b1};
                    end
                    P_DATA: begin
                        if (rnw_q) begin
                            m_cmd_d = (cnt_q == '0) ? (C_READ | C_NACK | C_STOP) : C_READ;
                            m_dat_d = 8'hff;
                        end else begin
                            m_cmd_d = (cnt_q == '0) ? (C_WRTE | C_STOP) : C_WRTE;
                            m_dat_d = wr_data;
                        end
                    end
                    default: begin
                        m_cmd_d = C_STOP;
                        m_dat_d = 8'hff;
                    end
                endcase
            end

            // The master accepts the command on the edge where it is not busy.
            ST_ISSUE: begin
                if (!m_stat[SB_BSY]) begin
                    m_ws_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!m_stat[SB_BSY] && m_stat[SB_DON]) begin
                    state_d = ST_EVAL;
                end
            end

            ST_EVAL: begin
                if (stat_code == S_ALO) begin
                    err_d = E_ALO;
                    fin   = 1'b1;
                end else if (stat_code == S_BBL) begin
                    err_d = E_BBL;
                    fin   = 1'b1;
                end else if (stat_code != S_OK) begin
                    err_d = E_CMD;
                    fin   = 1'b1;
                end else if (phase_q == P_STOP) begin
                    fin = 1'b1;
                end else if (!rd_byte && !m_stat[SB_ACK]) begin
                    case (phase_q)
                        P_ADDR, P_RADDR: err_d = E_DNACK;
                        P_REG:           err_d = E_RNACK;
                        default:         err_d = E_WNACK;
                    endcase
                    // A NACKed byte that already carried STOP needs no extra STOP.
                    if (last_wr) begin
                        fin = 1'b1;
                    end else begin
                        phase_d = P_STOP;
                        state_d = ST_LOAD;
                    end
                end else begin
                    if (rd_byte) begin
                        rd_data_d  = m_dat_out;
                        rd_valid_d = 1'b1;
                    end
                    case (phase_q)
                        P_ADDR: begin
                            phase_d = P_REG;
                            state_d = ST_LOAD;
                        end
                        P_REG: begin
                            phase_d = rnw_q ? P_RADDR : P_DATA;
                            state_d = ST_LOAD;
                        end
                        P_RADDR: begin
                            phase_d = P_DATA;
                            state_d = ST_LOAD;
                        end
                        default: begin
                            if (cnt_q != '0) begin
                                cnt_d   = cnt_q - LEN_W'(1);
                                state_d = ST_LOAD;
                            end else begin
                                fin = 1'b1;
                            end
                        end
                    endcase
                end
                if (fin) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered-output flops; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= P_ADDR;
            rnw_q      <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= E_OK;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            m_cmd_q    <= '0;
            m_dat_q    <= '0;
            m_ws_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            phase_q    <= phase_d;
            rnw_q      <= rnw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            m_cmd_q    <= m_cmd_d;
            m_dat_q    <= m_dat_d;
            m_ws_q     <= m_ws_d;
        end
    end

    // wr_take marks the cycle in which wr_data is captured into m_dat, so it
    // is decoded from the current state rather than delayed by a register.
    assign wr_take  = (state_q == ST_LOAD) && (phase_q == P_DATA) && !rnw_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign m_cmd    = m_cmd_q;
    assign m_dat    = m_dat_q;
    assign m_ws     = m_ws_q;

endmodule

// File: tb/tb_i2c_reg_xfer.sv
// Testbench for i2c_reg_xfer: a behavioural byte-level master/slave model,
// a command scoreboard and a table of register transactions.
module tb_i2c_reg_xfer;

    // Command words as the master sees them: STRT=1 STOP=2 READ=4 WRTE=8 NACK=16.
    localparam logic [4:0] SW  = 5'd9;   // STRT|WRTE
    localparam logic [4:0] W   = 5'd8;   // WRTE
    localparam logic [4:0] WS  = 5'd10;  // WRTE|STOP
    localparam logic [4:0] RD  = 5'd4;   // READ
    localparam logic [4:0] RNS = 5'd22;  // READ|NACK|STOP
    localparam logic [4:0] SP  = 5'd2;   // STOP
    localparam int BOOT_CYC = 20;
    localparam int NV = 12;

    typedef struct packed {
        logic            rnw;
        logic [6:0]      dev;
        logic [7:0]      reg_a;
        logic [2:0]      len;
        logic [7:0][7:0] data;        // write bytes / slave read bytes, byte 0 first
        int              fault_at;    // command index that fails, -1 = none
        logic [2:0]      fault_kind;  // 0 = slave NACK, else master error code
        int              n_cmd;
        logic [11:0][4:0] cmd;
        logic [11:0][7:0] dat;
        logic [2:0]      exp_err;
        int              exp_take;
        int              exp_rdv;
    } vec_t;

    logic       clk, rst, req, rnw;
    logic [6:0] dev;
    logic [7:0] reg_a, wr_data, rd_data, m_dat, m_dat_out;
    logic [2:0] len, err;
    logic       wr_take, rd_valid, busy, done, m_ws;
    logic [4:0] m_cmd;
    logic [5:0] m_stat;

    logic       m_bsy, m_don, m_ack;
    logic [2:0] m_code;
    assign m_stat = {m_code, m_ack, m_don, m_bsy};

    vec_t vecs [NV];
    vec_t cur;
    logic [12:0] exp_q [$];
    logic [7:0]  rd_q [$];
    int n_checks = 0, n_fail = 0;
    int take_cnt, rdv_cnt, done_cnt, cmd_idx, rd_idx, wr_idx;
    logic wr_adv;
    logic [2:0] prev_err;

    i2c_reg_xfer #(.LEN_W(3), .C_SZ(5), .S_SZ(6)) dut (
        .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev(dev), .reg_a(reg_a),
        .len(len), .wr_data(wr_data), .wr_take(wr_take), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws), .m_stat(m_stat),
        .m_dat_out(m_dat_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Master + slave model: accepts a command on the edge after a negedge
    // where m_ws=1 and BSY=0, stays busy a few cycles, then reports DON.
    logic       accepting, have_res, res_ack;
    logic [2:0] res_code;
    logic [7:0] res_dat;
    int         bsy_cnt;
    logic [12:0] exp_c;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_bsy = 1'b1; m_don = 1'b0; m_ack = 1'b0; m_code = 3'd0; m_dat_out = 8'h00;
            bsy_cnt = BOOT_CYC; accepting = 1'b0; have_res = 1'b0;
        end else if (accepting) begin
            accepting = 1'b0;
            m_bsy = 1'b1; m_don = 1'b0;
            bsy_cnt = 2 + (cmd_idx % 3);
            have_res = 1'b1;
        end else begin
            if (bsy_cnt > 0) begin
                bsy_cnt--;
                if (bsy_cnt == 0) begin
                    m_bsy = 1'b0;
                    if (have_res) begin
                        m_don = 1'b1; m_ack = res_ack; m_code = res_code; m_dat_out = res_dat;
                        have_res = 1'b0;
                    end
                end
            end
            if (bsy_cnt == 0 && !m_bsy && m_ws) begin
                check("cmd_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_c = exp_q.pop_front();
                    check("m_cmd", m_cmd, exp_c[12:8]);
                    if (exp_c[12:8] != SP) check("m_dat", m_dat, exp_c[7:0]);
                end
                res_ack = 1'b1; res_code = 3'd0; res_dat = 8'h00;
                if (cmd_idx == cur.fault_at) begin
                    res_ack = 1'b0;
                    res_code = cur.fault_kind;
                end
                if (m_cmd[2]) begin
                    res_dat = cur.data[rd_idx];
                    if (rd_idx < 7) rd_idx++;
                end
                cmd_idx++;
                accepting = 1'b1;
            end
        end
    end

    // Monitors: write-data supply, read-data scoreboard, pulse counters.
    always @(negedge clk) begin
        if (wr_adv) begin
            wr_adv = 1'b0;
            if (wr_idx < 7) wr_idx++;
            wr_data = cur.data[wr_idx];
        end
        if (wr_take) begin
            take_cnt++;
            wr_adv = 1'b1;
        end
        if (rd_valid) begin
            rdv_cnt++;
            check("rd_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) check("rd_data", rd_data, rd_q.pop_front());
        end
        if (done) done_cnt++;
    end

    task automatic set_vec(input int i, input logic r, input logic [6:0] d, input logic [7:0] ra,
                           input logic [2:0] l, input logic [63:0] data, input int fat,
                           input logic [2:0] fk, input logic [2:0] ee, input int et, input int er);
        vecs[i] = '0;
        vecs[i].rnw = r; vecs[i].dev = d; vecs[i].reg_a = ra; vecs[i].len = l;
        vecs[i].data = data; vecs[i].fault_at = fat; vecs[i].fault_kind = fk;
        vecs[i].exp_err = ee; vecs[i].exp_take = et; vecs[i].exp_rdv = er;
    endtask

    task automatic add_cmd(input int i, input logic [4:0] c, input logic [7:0] d);
        vecs[i].cmd[vecs[i].n_cmd] = c;
        vecs[i].dat[vecs[i].n_cmd] = d;
        vecs[i].n_cmd = vecs[i].n_cmd + 1;
    endtask

    task automatic build_vectors();
        set_vec(0, 0, 7'h50, 8'h10, 3'd1, 64'h5AA5, -1, 0, 0, 2, 0);
        add_cmd(0, SW, 8'hA0); add_cmd(0, W, 8'h10); add_cmd(0, W, 8'hA5); add_cmd(0, WS, 8'h5A);
        set_vec(1, 1, 7'h50, 8'h02, 3'd2, 64'h332211, -1, 0, 0, 0, 3);
        add_cmd(1, SW, 8'hA0); add_cmd(1, W, 8'h02); add_cmd(1, SW, 8'hA1);
        add_cmd(1, RD, 8'hFF); add_cmd(1, RD, 8'hFF); add_cmd(1, RNS, 8'hFF);
        set_vec(2, 0, 7'h50, 8'h10, 3'd1, 64'h5AA5, 0, 0, 1, 0, 0);
        add_cmd(2, SW, 8'hA0); add_cmd(2, SP, 8'h00);
        set_vec(3, 0, 7'h2A, 8'h33, 3'd3, 64'h04030201, 4, 0, 3, 3, 0);
        add_cmd(3, SW, 8'h54); add_cmd(3, W, 8'h33); add_cmd(3, W, 8'h01);
        add_cmd(3, W, 8'h02); add_cmd(3, W, 8'h03); add_cmd(3, SP, 8'h00);
        set_vec(4, 0, 7'h50, 8'h10, 3'd0, 64'h77, 0, 1, 4, 0, 0);
        add_cmd(4, SW, 8'hA0);
        set_vec(5, 1, 7'h3C, 8'h7F, 3'd0, 64'h99, 1, 0, 2, 0, 0);
        add_cmd(5, SW, 8'h78); add_cmd(5, W, 8'h7F); add_cmd(5, SP, 8'h00);
        set_vec(6, 1, 7'h7F, 8'hFF, 3'd0, 64'hC3, -1, 0, 0, 0, 1);
        add_cmd(6, SW, 8'hFE); add_cmd(6, W, 8'hFF); add_cmd(6, SW, 8'hFF); add_cmd(6, RNS, 8'hFF);
        set_vec(7, 0, 7'h50, 8'h44, 3'd0, 64'h9E, 2, 0, 3, 1, 0);
        add_cmd(7, SW, 8'hA0); add_cmd(7, W, 8'h44); add_cmd(7, WS, 8'h9E);
        set_vec(8, 1, 7'h50, 8'h01, 3'd1, 64'h0, 2, 0, 1, 0, 0);
        add_cmd(8, SW, 8'hA0); add_cmd(8, W, 8'h01); add_cmd(8, SW, 8'hA1); add_cmd(8, SP, 8'h00);
        set_vec(9, 0, 7'h21, 8'h00, 3'd7, 64'h8786858483828180, -1, 0, 0, 8, 0);
        add_cmd(9, SW, 8'h42); add_cmd(9, W, 8'h00);
        for (int b = 0; b < 7; b++) add_cmd(9, W, 8'h80 + 8'(b));
        add_cmd(9, WS, 8'h87);
        set_vec(10, 1, 7'h50, 8'h05, 3'd0, 64'h0, 0, 2, 5, 0, 0);
        add_cmd(10, SW, 8'hA0);
        set_vec(11, 0, 7'h50, 8'h20, 3'd0, 64'h3C, 2, 3, 6, 1, 0);
        add_cmd(11, SW, 8'hA0); add_cmd(11, W, 8'h20); add_cmd(11, WS, 8'h3C);
    endtask

    // Load a vector into the model and scoreboard and present its inputs.
    task automatic arm(input vec_t v);
        cur = v;
        exp_q.delete();
        rd_q.delete();
        for (int i = 0; i < v.n_cmd; i++) exp_q.push_back({v.cmd[i], v.dat[i]});
        for (int i = 0; i < v.exp_rdv; i++) rd_q.push_back(v.data[i]);
        take_cnt = 0; rdv_cnt = 0; done_cnt = 0; cmd_idx = 0; rd_idx = 0; wr_idx = 0;
        wr_adv = 1'b0;
        wr_data = v.data[0];
        rnw = v.rnw; dev = v.dev; reg_a = v.reg_a; len = v.len;
    endtask

    task automatic pulse_req(input logic [2:0] held_err);
        check("idle_busy", busy, 0);
        check("err_held", err, held_err);
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        check("busy_rise", busy, 1);
        check("err_cleared", err, 0);
    endtask

    task automatic finish(input vec_t v);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        #1;
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        check("err", err, v.exp_err);
        check("wr_take_count", take_cnt, v.exp_take);
        check("rd_valid_count", rdv_cnt, v.exp_rdv);
        check("done_count", done_cnt, 1);
        check("cmds_left", exp_q.size(), 0);
        check("rd_left", rd_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; rnw = 1'b0; dev = '0; reg_a = '0; len = '0; wr_data = '0;
        cur = '0;
        cur.fault_at = -1;
        build_vectors();

        // req held from reset: command waits in ISSUE through the master's boot BSY.
        arm(vecs[0]);
        req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_m_ws", m_ws, 0);
        check("rst_m_cmd", m_cmd, 0);
        check("rst_m_dat", m_dat, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_take", wr_take, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("ws_held_boot", m_ws, 1);
        check("no_accept_boot", cmd_idx, 0);
        check("busy_boot", busy, 1);
        finish(vecs[0]);
        // req still high in the done cycle: second transaction starts at once.
        arm(vecs[0]);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        finish(vecs[0]);

        prev_err = 3'd0;
        for (int i = 1; i < NV; i++) begin
            arm(vecs[i]);
            pulse_req(prev_err);
            finish(vecs[i]);
            @(negedge clk);
            check("done_pulse", done, 0);
            prev_err = vecs[i].exp_err;
        end

        // Reset in the middle of a write: abort, no done, outputs back to reset.
        arm(vecs[3]);
        pulse_req(prev_err);
        for (int i = 0; i < 2000 && cmd_idx < 3; i++) @(negedge clk);
        check("abort_reached", cmd_idx >= 3, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_m_ws", m_ws, 0);
        check("abort_err", err, 0);
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", done_cnt, 0);

        // Recovery after reset.
        arm(vecs[1]);
        pulse_req(3'd0);
        finish(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, actual running required finished");
        $fatal(1);
    end

endmodule
